// File: rtl/wb_port_arbiter_pkg.sv
// Shared defines for the writeback port arbiter: default sizes, requester
// ordering and the source-index width helper.
package wb_port_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int RES_W_DEF   = 64;
    localparam int PREG_W_DEF  = 6;

    typedef enum logic [1:0] {
        REQ_ALU    = 2'd0,
        REQ_BJU    = 2'd1,
        REQ_MULDIV = 2'd2,
        REQ_LSU    = 2'd3
    } req_idx_e;

    // A single requester still needs a 1-bit source field.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester and writeback-side bus of the port arbiter; slave is the
// arbiter's view, master the execution pipes plus downstream pipe register.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int PREG_W  = PREG_W_DEF
) ();
    localparam int SRC_W = src_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*PREG_W-1:0] req_prd;
    logic [NUM_REQ*RES_W-1:0]  req_result;
    logic [NUM_REQ-1:0]        req_need_to_wb;
    logic                      flush_valid;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [PREG_W-1:0]         wb_prd;
    logic [RES_W-1:0]          wb_result;
    logic                      wb_need_to_wb;
    logic [SRC_W-1:0]          wb_src;
    logic [31:0]               wb_count;

    modport slave (
        input  req_valid, req_prd, req_result, req_need_to_wb, flush_valid, wb_ready,
        output req_ready, wb_valid, wb_prd, wb_result, wb_need_to_wb, wb_src, wb_count
    );

    modport master (
        output req_valid, req_prd, req_result, req_need_to_wb, flush_valid, wb_ready,
        input  req_ready, wb_valid, wb_prd, wb_result, wb_need_to_wb, wb_src, wb_count
    );

endinterface

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ.
module wb_port_arbiter_rr_pick
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int SRC_W  = src_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   idx
);

    logic             found;
    logic [SRC_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates execution-pipe writebacks into one registered output entry;
// round-robin fairness, 1-cycle latency, full throughput when drained each cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int PREG_W  = PREG_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_port_arbiter_if.slave bus
);

    localparam int               SRC_W = src_width(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST  = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic               can_accept;
    logic               grant_en;
    logic               in_fire;

    logic [PREG_W-1:0]  prd_arr [NUM_REQ];
    logic [RES_W-1:0]   res_arr [NUM_REQ];

    logic               wb_valid_q;
    logic [PREG_W-1:0]  wb_prd_q;
    logic [RES_W-1:0]   wb_result_q;
    logic               wb_need_to_wb_q;
    logic [SRC_W-1:0]   wb_src_q;
    logic [31:0]        wb_count_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign prd_arr[i] = bus.req_prd[i*PREG_W +: PREG_W];
        assign res_arr[i] = bus.req_result[i*RES_W +: RES_W];
    end

    wb_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (win_grant),
        .idx   (win_idx)
    );

    // reset_n gates the grant so no requester sees an accept while held in reset
    assign can_accept    = ~wb_valid_q | bus.wb_ready;
    assign grant_en      = can_accept & ~bus.flush_valid & reset_n;
    assign bus.req_ready = grant_en ? win_grant : '0;
    assign in_fire       = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q      <= 1'b0;
            wb_prd_q        <= '0;
            wb_result_q     <= '0;
            wb_need_to_wb_q <= 1'b0;
            wb_src_q        <= '0;
            wb_count_q      <= '0;
            rr_ptr_q        <= '0;
        end else if (bus.flush_valid) begin
            wb_valid_q      <= 1'b0;
            wb_prd_q        <= '0;
            wb_result_q     <= '0;
            wb_need_to_wb_q <= 1'b0;
            wb_src_q        <= '0;
        end else if (in_fire) begin
            wb_valid_q      <= 1'b1;
            wb_prd_q        <= prd_arr[win_idx];
            wb_result_q     <= res_arr[win_idx];
            wb_need_to_wb_q <= bus.req_need_to_wb[win_idx];
            wb_src_q        <= win_idx;
            wb_count_q      <= wb_count_q + 32'd1;
            rr_ptr_q        <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
        end else if (wb_valid_q && bus.wb_ready) begin
            wb_valid_q      <= 1'b0;
        end
    end

    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_prd        = wb_prd_q;
    assign bus.wb_result     = wb_result_q;
    assign bus.wb_need_to_wb = wb_need_to_wb_q;
    assign bus.wb_src        = wb_src_q;
    assign bus.wb_count      = wb_count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference model predicts grants and
// queues expected entries, which are popped and compared when the DUT drains them.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    wb_port_arbiter_if #(.NUM_REQ(4), .RES_W(64), .PREG_W(6)) bus ();

    wb_port_arbiter #(.NUM_REQ(4), .RES_W(64), .PREG_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [5:0]  prd;
        logic [63:0] result;
        logic        need;
        logic [1:0]  src;
    } entry_t;

    entry_t      sb[$];
    logic [5:0]  prd [4];
    logic [63:0] res [4];
    logic [3:0]  need;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_count;

    function automatic logic [3:0] m_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (((v >> ((p + k) % 4)) & 4'b0001) != 4'b0000)
                return 4'(1 << ((p + k) % 4));
        end
        return 4'b0000;
    endfunction

    task automatic drive_payload();
        bus.req_prd        = {prd[3], prd[2], prd[1], prd[0]};
        bus.req_result     = {res[3], res[2], res[1], res[0]};
        bus.req_need_to_wb = need;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_count = 32'd0;
        sb.delete();
    endtask

    // One clock: predict and check at the falling edge, then return at posedge+1.
    task automatic tick();
        logic [3:0] exp_ready;
        logic       drain;
        entry_t     e;
        entry_t     act;
        int         w;
        @(negedge clock);
        exp_ready = (bus.flush_valid || (m_valid && !bus.wb_ready)) ? 4'b0000
                                                                    : m_pick(bus.req_valid, m_ptr);
        n_tests++;
        if (bus.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL tick_req_ready: got %b want %b", bus.req_ready, exp_ready);
        end
        n_tests++;
        if (bus.wb_valid !== m_valid) begin
            n_fail++;
            $display("FAIL tick_wb_valid: got %b want %b", bus.wb_valid, m_valid);
        end
        n_tests++;
        if (bus.wb_count !== m_count) begin
            n_fail++;
            $display("FAIL tick_wb_count: got %h want %h", bus.wb_count, m_count);
        end
        drain = m_valid && bus.wb_ready;
        if (drain) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: drain with no expected entry");
            end else begin
                e   = sb.pop_front();
                act = '{prd: bus.wb_prd, result: bus.wb_result, need: bus.wb_need_to_wb, src: bus.wb_src};
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL sb_entry: got prd=%h res=%h need=%b src=%0d want prd=%h res=%h need=%b src=%0d",
                             act.prd, act.result, act.need, act.src, e.prd, e.result, e.need, e.src);
                end
            end
        end
        if (bus.flush_valid) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (exp_ready != 4'b0000) begin
            w = 0;
            for (int i = 0; i < 4; i++) if (exp_ready == 4'(1 << i)) w = i;
            sb.push_back('{prd: prd[w], result: res[w], need: need[w], src: 2'(w)});
            m_valid = 1'b1;
            m_ptr   = (w + 1) % 4;
            m_count = m_count + 32'd1;
        end else if (drain) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        bus.req_valid   = 4'b0000;
        bus.flush_valid = 1'b0;
        bus.wb_ready    = 1'b0;
        reset_n         = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.wb_ready  = 1'b1;
        reset_n       = 1'b0;
        #1;
        n_tests++;
        if ({bus.wb_valid, bus.wb_prd, bus.wb_result, bus.wb_need_to_wb, bus.wb_src} !== '0 ||
            bus.wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b prd=%h res=%h cnt=%h want all zero",
                     bus.wb_valid, bus.wb_prd, bus.wb_result, bus.wb_count);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        end
        reset_n = 1'b1;
        model_reset();
        bus.req_valid = 4'b1010;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 0010", bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            prd[i] = 6'(i + 1);
            res[i] = 64'h1000 + 64'(i);
        end
        need = 4'b0101;
        drive_payload();
        bus.wb_ready  = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.req_ready !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << (k % 4)));
            end
            n_tests++;
            if (bus.wb_valid !== (k > 0)) begin
                n_fail++;
                $display("FAIL rr_wb_valid[%0d]: got %b want %b", k, bus.wb_valid, (k > 0));
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        n_tests++;
        if (bus.wb_count !== 32'd5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d want 5", bus.wb_count);
        end
        tick();
    endtask

    task automatic test_alternate();
        apply_reset();
        bus.wb_ready  = 1'b1;
        bus.req_valid = 4'b0101;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (bus.req_ready !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: got %b want %b", k, bus.req_ready,
                         (k % 2 == 0) ? 4'b0001 : 4'b0100);
            end
            n_tests++;
            if (bus.req_ready[1] !== 1'b0 || bus.req_ready[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL alt_idle_ready[%0d]: got %b want x0x0", k, bus.req_ready);
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        apply_reset();
        prd[1]  = 6'h15;
        res[1]  = 64'hDEAD;
        need[1] = 1'b1;
        prd[2]  = 6'h22;
        res[2]  = 64'hBEEF;
        drive_payload();
        bus.wb_ready  = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        tick();
        bus.req_valid = 4'b0110;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.wb_valid !== 1'b1 || bus.wb_prd !== 6'h15 || bus.wb_result !== 64'hDEAD ||
                bus.wb_src !== 2'd1 || bus.wb_need_to_wb !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_payload[%0d]: got v=%b prd=%h res=%h src=%0d want 1 15 dead 1",
                         k, bus.wb_valid, bus.wb_prd, bus.wb_result, bus.wb_src);
            end
            n_tests++;
            if (bus.req_ready !== 4'b0000 || bus.wb_count !== 32'd1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ready=%b cnt=%0d want 0000 1", k, bus.req_ready, bus.wb_count);
            end
            tick();
        end
        bus.wb_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_next_grant: got %b want 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        n_tests++;
        if (bus.wb_valid !== 1'b1 || bus.wb_src !== 2'd2 || bus.wb_prd !== 6'h22) begin
            n_fail++;
            $display("FAIL stall_zero_bubble: got v=%b src=%0d prd=%h want 1 2 22", bus.wb_valid, bus.wb_src, bus.wb_prd);
        end
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        prd[3]  = 6'h2A;
        res[3]  = 64'hCAFE_F00D;
        need[3] = 1'b1;
        drive_payload();
        bus.wb_ready  = 1'b0;
        bus.req_valid = 4'b1000;
        #1;
        tick();
        bus.flush_valid = 1'b1;
        #1;
        n_tests++;
        if (bus.wb_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_cycle: got v=%b ready=%b want 1 0000", bus.wb_valid, bus.req_ready);
        end
        tick();
        bus.flush_valid = 1'b0;
        #1;
        n_tests++;
        if ({bus.wb_valid, bus.wb_prd, bus.wb_result, bus.wb_need_to_wb, bus.wb_src} !== '0) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b prd=%h res=%h need=%b src=%0d want all zero",
                     bus.wb_valid, bus.wb_prd, bus.wb_result, bus.wb_need_to_wb, bus.wb_src);
        end
        n_tests++;
        if (bus.wb_count !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_count: got %0d want 1", bus.wb_count);
        end
        bus.wb_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL flush_regrant: got %b want 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        bus.wb_ready  = 1'b1;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        m_count = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        n_tests++;
        if (bus.wb_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h want ffffffff", bus.wb_count);
        end
        bus.req_valid = 4'b0001;
        #1;
        tick();
        bus.req_valid = 4'b0000;
        n_tests++;
        if (bus.wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_count: got %h want 00000000", bus.wb_count);
        end
        tick();
    endtask

    task automatic test_reset_async();
        bus.wb_ready  = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.wb_valid !== 1'b0 || bus.wb_count !== 32'd0 || dut.rr_ptr_q !== 2'd0 || bus.wb_prd !== 6'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b cnt=%0d ptr=%0d prd=%h want 0 0 0 0",
                     bus.wb_valid, bus.wb_count, dut.rr_ptr_q, bus.wb_prd);
        end
        n_tests++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_ready: got %b want 0000", bus.req_ready);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        bus.req_valid = 4'b1100;
        bus.wb_ready  = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL async_first_grant: got %b want 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                prd[i] = 6'($urandom);
                res[i] = {$urandom, $urandom};
            end
            need = 4'($urandom);
            drive_payload();
            bus.req_valid   = 4'($urandom);
            bus.wb_ready    = ($urandom_range(0, 3) != 0);
            bus.flush_valid = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.flush_valid = 1'b0;
        bus.req_valid   = 4'b0000;
        bus.wb_ready    = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_leftover: got %0d queued want 0", sb.size());
        end
    endtask

    initial begin
        bus.req_valid   = 4'b0000;
        bus.flush_valid = 1'b0;
        bus.wb_ready    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prd[i] = 6'd0;
            res[i] = 64'd0;
        end
        need = 4'b0000;
        drive_payload();
        model_reset();
        test_reset();
        test_round_robin();
        test_alternate();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_async();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of execution-pipe requesters (ALU, BJU, MULDIV, LSU order).
REQ-002 SHALL have parameter RES_W, default 64, result width (`RESULT_RANGE`).
REQ-003 SHALL have parameter PREG_W, default 6, physical register index width (`PREG_RANGE`).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester writeback valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-008 SHALL have port req_prd  input  NUM_REQ*PREG_W  packed destination pregs, requester i at bits [i*PREG_W +: PREG_W].
REQ-009 SHALL have port req_result  input  NUM_REQ*RES_W  packed results, same packing rule.
REQ-010 SHALL have port req_need_to_wb  input  NUM_REQ  regfile write enable per requester.
REQ-011 SHALL have port flush_valid  input  1  synchronous pipeline flush.
REQ-012 SHALL have port wb_valid  output  1  output entry valid toward the writeback pipe register.
REQ-013 SHALL have port wb_ready  input  1  downstream accept.
REQ-014 SHALL have port wb_prd, wb_result, wb_need_to_wb  output  PREG_W/RES_W/1  registered winner payload.
REQ-015 SHALL have port wb_src  output  2 (clog2 NUM_REQ)  index of the requester that produced the current entry.
REQ-016 SHALL have port wb_count  output  32  number of entries accepted since reset; wraps 0xFFFFFFFF->0.

Function
REQ-017 SHALL hold one registered output entry; can_accept = ~wb_valid | wb_ready.
REQ-018 SHALL select the winner combinationally by round-robin over req_valid, searching from rr_ptr upward modulo NUM_REQ.
REQ-019 SHALL drive req_ready[winner] = can_accept & ~flush_valid; all other req_ready bits SHALL be 0; with no valid requester, all req_ready = 0.
REQ-020 On in_fire (req_valid[w] & req_ready[w]), SHALL load winner payload and wb_src, set wb_valid=1 next cycle, advance rr_ptr to (w+1) mod NUM_REQ, and increment wb_count by 1.
REQ-021 On wb_valid & wb_ready with no in_fire, SHALL clear wb_valid; payload registers SHALL hold their values.
REQ-022 Simultaneous drain and in_fire SHALL replace the entry with zero bubble (full throughput, 1 entry/cycle).
REQ-023 Latency SHALL be exactly 1 cycle from in_fire to wb_valid.
REQ-024 With wb_valid=1 and wb_ready=0, output payload SHALL be stable and all req_ready SHALL be 0.
REQ-025 flush_valid SHALL, next cycle, clear wb_valid and zero wb_prd, wb_result, wb_need_to_wb, wb_src; no grant SHALL occur in the flush cycle; rr_ptr and wb_count SHALL be preserved.
REQ-026 rr_ptr SHALL not change in cycles without in_fire.

Reset
REQ-027 Asserting reset_n low SHALL immediately set wb_valid=0, wb_prd=0, wb_result=0, wb_need_to_wb=0, wb_src=0, wb_count=0, rr_ptr=0.
REQ-028 During reset all req_ready SHALL be 0; reset mid-transfer SHALL discard the held entry without a drain.
REQ-029 After reset release, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-030 RESULT, PREG range macros and NUM_REQ default SHALL come from the shared defines package; requester index enum (ALU=0, BJU=1, MULDIV=2, LSU=3) SHALL live there.
REQ-031 The round-robin selector SHALL be one sub-module rr_pick (inputs valid vector, pointer; output one-hot grant and index), purely combinational; storage and counter SHALL stay in wb_port_arbiter.

Verification
REQ-032 Reset, req_valid=4'b1111, wb_ready=1 steady -> grants 0,1,2,3,0 on consecutive cycles; wb_valid high from cycle 2; wb_count=5 after 5 fires.
REQ-033 req_valid=4'b0101, wb_ready=1 -> alternating grants 0,2,0,2; req_ready[1] and [3] never high.
REQ-034 Entry from req 1 (prd=6'h15, result=64'hDEAD) with wb_ready=0 for 3 cycles -> payload stable, req_ready=0, wb_count unchanged; wb_ready=1 -> drains, next grant to req 2.
REQ-035 flush_valid pulsed while wb_valid=1 and req_valid=4'b1000 -> next cycle wb_valid=0, payload zero, no grant that cycle; following cycle req 3 granted.
REQ-036 Preload wb_count to 0xFFFFFFFF via 2^32-1 fires (or force) then one fire -> wb_count=0.
REQ-037 reset_n low asynchronously mid-cycle with wb_valid=1 -> wb_valid, wb_count, rr_ptr 0 before next clock edge; req_ready=0.
